// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 8-digit time-multiplexed seven-segment scanner
//
// Latches a packed 8-digit BCD word plus per-digit decimal-point requests on
// a load strobe and scans the digits round-robin, one digit per refresh slot
// of REFRESH_DIV clock cycles. All display outputs are registered.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant non-zero nibble are
//   blanked (digit 0 is always shown; invalid nibbles count as non-zero).
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   bcd_in  - packed BCD, nibble k is digit k (digit 0 least significant)
//   dp_in   - per-digit decimal-point request, 1 = lit
//   load    - capture bcd_in/dp_in at this edge
//   an      - active-low digit anodes (one-hot-low or all high)
//   seg     - active-low segments {g,f,e,d,c,b,a}
//   dp      - active-low decimal point

module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bcd_in,
    input  logic [7:0]  dp_in,
    input  logic        load,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    logic [31:0]   bcd_q,     bcd_d;
    logic [7:0]    dp_in_q,   dp_in_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    idx_q,     idx_d;
    logic [7:0]    an_q,      an_d;
    logic [6:0]    seg_q,     seg_d;
    logic          dp_out_q,  dp_out_d;

    logic [3:0]    nib;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;  // invalid BCD shown as a dash
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // lead_zero[k] is set when nibbles k..7 of the snapshot are all zero
    logic [7:0] lead_zero;
    logic       blank;

    always_comb begin
        lead_zero    = 8'h00;
        lead_zero[7] = (bcd_q[31:28] == 4'd0);
        for (int k = 6; k >= 0; k--) begin
            lead_zero[k] = lead_zero[k+1] && (bcd_q[4*k +: 4] == 4'd0);
        end
        blank = (idx_q != 3'd0) && lead_zero[idx_q];
    end
`endif

    always_comb begin
        bcd_d     = load ? bcd_in : bcd_q;
        dp_in_d   = load ? dp_in  : dp_in_q;

        div_cnt_d = div_cnt_q + CW'(1);
        idx_d     = idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 3'd1;
        end

        // Outputs reflect the digit selected before this edge
        nib      = bcd_q[{idx_q, 2'b00} +: 4];
        an_d     = ~(8'b1 << idx_q);
        seg_d    = decode(nib);
        dp_out_d = ~dp_in_q[idx_q];

`ifdef LEADING_ZERO_BLANK_EN
        if (blank) begin
            an_d     = 8'hFF;
            seg_d    = 7'h7F;
            dp_out_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q     <= '0;
            dp_in_q   <= '0;
            div_cnt_q <= '0;
            idx_q     <= '0;
            an_q      <= 8'hFF;
            seg_q     <= 7'h7F;
            dp_out_q  <= 1'b1;
        end else begin
            bcd_q     <= bcd_d;
            dp_in_q   <= dp_in_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_out_q  <= dp_out_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_out_q;

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed 8-digit seven-segment display driver that consumes the packed 32-bit BCD word produced by the binary-to-BCD converter, one nibble per digit. The block latches a BCD snapshot on a load strobe and scans the eight digits round-robin, one digit per refresh slot. It drives active-low anodes, segments and decimal point for the board display.

## Interface
- REFRESH_DIV, 100000, clock cycles each digit stays selected; legal range ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bcd_in  input  32  packed BCD; nibble k (bits 4k+3:4k) is decimal digit k, digit 0 least significant.
- dp_in  input  8  decimal-point request per digit, 1 = lit.
- load  input  1  1 = capture bcd_in and dp_in at this edge.
- an  output  8  active-low digit anodes, one-hot-low or all high.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.

## Operation
- Registers: bcd_q[31:0], dp_q[7:0] (snapshot); div_cnt, width clog2(REFRESH_DIV); idx[2:0] (selected digit).
- Snapshot: when load=1, bcd_q<=bcd_in, dp_q<=dp_in. Otherwise held. No handshake; load accepted every cycle it is high.
- Divider: div_cnt increments each cycle; at REFRESH_DIV-1 it returns to 0 and idx increments, wrapping 7→0.
- Decode of nibble n = bcd_q[4*idx+3 : 4*idx]: 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10; 10–15 (invalid BCD) → dash 7'h3F.
- Output register update every non-reset cycle: an <= ~(8'b1 << idx), seg <= decode(n), dp <= ~dp_q[idx]; blanking (Configuration) overrides.
- Reset values: an=8'hFF, seg=7'h7F, dp=1, bcd_q=0, dp_q=0, div_cnt=0, idx=0.

## Timing
- All outputs registered; outputs reflect idx/bcd_q/dp_q values as they stood before the edge (one-cycle lag).
- First edge with rst=0: an=8'hFE, seg=7'h40, dp=1.
- Each digit occupies exactly REFRESH_DIV consecutive cycles on an; full scan = 8×REFRESH_DIV cycles.
- load at edge E: new data visible on outputs from edge E+1.
- load coincident with idx advance: both take effect; edge E+1 shows new digit from new data.
- load held high continuously: snapshot tracks bcd_in with one-cycle lag, scanning unaffected.
- rst asserted mid-scan: at that edge all registers/outputs take reset values; scan restarts at digit 0, snapshot cleared.
- Never more than one an bit low in any cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit k (k ≥ 1) is blanked when nibbles k..7 of bcd_q are all 0; blanked slot drives an=8'hFF, seg=7'h7F, dp=1 for its full slot time, even if dp_q[k]=1. Digit 0 never blanked. Invalid nibbles count as non-zero.
- Not defined: all eight digits always displayed, leading zeros shown as 7'h40.

## Test plan
- Reset/first scan (REFRESH_DIV=4, no load): after rst release an steps FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles then back to FE; seg=7'h40 throughout; during rst an=FF, seg=7F, dp=1.
- Load 32'h8765_4321, dp_in=8'h04: digit slots show seg 79,24,30,19,12,02,78,00 for digits 0–7; dp=0 only during digit 2 slot.
- Invalid BCD: load 32'h0000_00AF → digits 0 and 1 show 7'h3F; with LEADING_ZERO_BLANK_EN digits 2–7 blank (an=FF), without it they show 7'h40.
- Blanking with LEADING_ZERO_BLANK_EN: load 32'h0000_0000 → only digit 0 lit with 7'h40; load 32'h0010_0005 → digits 0–5 lit (5,0,0,0,0,1), digits 6–7 an=FF.
- Load on advance edge: load 32'h1111_1111 on the cycle idx 0→1; the next output shows an=FD, seg=7'h79.
- Reset mid-scan: assert rst during digit 5 slot after loading 32'h9999_9999 → next edge an=FF; after release digit 0 shows 7'h40 (snapshot cleared), scan restarts at digit 0 with full REFRESH_DIV slot.
